ifetch_queue: RTL and testbench
===============================

Name: ifetch_queue

Overview:
- Parametrised RV32IC instruction-fetch unit: next generation of the single-entry instruction cache front end.
- Issues one-outstanding fetches to the memory controller and predecodes each returned word: 32-bit vs compressed, JAL/C.J/C.JAL targets, optional backward-taken branch prediction.
- Buffers fetched instructions in a DEPTH-entry circular queue with PC and prediction metadata.
- Feeds decode/issue through a valid/ready port; flushes on back-end redirect.

Parameters:
- DEPTH, 16, queue entries; power of 2, ≥2.
- ADDR_W, 32, PC and address width.
- RESET_PC, 0, fetch PC after reset.
- PREDICT_BWD, 1: 1 predicts backward conditional branches (B-type, C.BEQZ, C.BNEZ) taken; 0 predicts all not-taken.

Ports:
- clk  in  1  clock; all state updates on posedge.
- rst_n  in  1  asynchronous, active-low reset.
- stall  in  1  back end full (LSB or IQ); blocks new requests.
- mem_req  out  1  one-cycle fetch request pulse.
- mem_addr  out  ADDR_W  request address, halfword aligned.
- mem_valid  in  1  response strobe, ≥1 cycle after mem_req.
- mem_data  in  32  32 bits starting at mem_addr.
- redirect_valid  in  1  mispredict or JALR resolution.
- redirect_pc  in  ADDR_W  corrected PC.
- out_valid  out  1  queue head valid.
- deq_ready  in  1  consumer accepts head.
- out_inst  out  32  head instruction; compressed forms zero-extended from bits 15:0.
- out_pc  out  ADDR_W  head PC.
- out_is_c  out  1  head is 16-bit.
- out_pred_pc  out  ADDR_W  predicted next PC for head.
- count  out  $clog2(DEPTH)+1  occupancy.

Behaviour:
- Reset (async assert, sync release):
  - fetch_pc=RESET_PC, FSM=IDLE, head=tail=0, count=0, drop=0.
  - mem_req=0, mem_addr=RESET_PC, out_valid=0.
- FSM states:
  - IDLE: issue when !stall && count<DEPTH && !redirect_valid. Register mem_req=1 for exactly one cycle and mem_addr=fetch_pc, then go to WAIT.
  - WAIT: on mem_valid, predecode, write entry at tail (unless drop), set fetch_pc=predicted next PC. Go to HALT if the instruction is indirect, else IDLE.
  - HALT: no requests until redirect_valid.
- Predecode. Word is 32-bit iff mem_data[1:0]==11; otherwise compressed, using bits 15:0 only.
  - JAL (0x6F): target = pc + sign-extended J-immediate.
  - B-type (0x63): if PREDICT_BWD and imm[12]==1, target = pc + sign-extended B-immediate; else pc+4.
  - JALR (0x67): indirect, go to HALT.
  - C.J (op 01, funct3 101) and C.JAL (op 01, funct3 001): target = pc + sign-extended CJ-immediate.
  - C.BEQZ/C.BNEZ (op 01, funct3 110/111): backward-taken rule, using CB-immediate.
  - C.JR/C.JALR (op 10, funct3 100, rs2=0, rs1≠0): indirect, go to HALT.
  - All others: pc+4 (32-bit) or pc+2 (compressed).
  - All PC arithmetic is modulo 2^ADDR_W.
- Indirect entries are enqueued with out_pred_pc = pc+len; the back end must redirect.
- Queue:
  - out_valid = count≠0; outputs come straight from head registers (no extra latency).
  - Dequeue when out_valid && deq_ready.
  - Simultaneous enqueue and dequeue leaves count unchanged.
  - head and tail wrap modulo DEPTH.
  - The issue gate count<DEPTH plus single outstanding request guarantees no overflow. An enqueue at count==DEPTH is an assertion failure.
- Redirect (highest priority over mem_valid, dequeue and issue in the same cycle):
  - Clear the queue (head=tail=count=0) and set fetch_pc=redirect_pc.
  - From WAIT, set drop=1 and stay in WAIT: the next mem_valid is discarded, clears drop, and goes to IDLE.
  - From IDLE/HALT, go to IDLE.
  - No mem_req in the redirect cycle. The first request for redirect_pc appears no earlier than the following cycle.
- stall only gates new requests; an in-flight response is still accepted and enqueued.
- Minimum fetch loop: mem_req at cycle t; with mem_valid at t+1, the entry is visible on out_valid at t+2 and the next mem_req is at t+2.

Test Plan:
- Reset, then a stream of 4 ADDI words with 1-cycle memory → mem_addr 0,4,8,C; out_pc 0,4,8,C; count climbs while deq_ready=0 and stops requesting at DEPTH.
- C.ADDI (0x0505) at 0, then JAL x0,+0x100 (0x1000006F) at 2 → next mem_addr 0x102; out_is_c=1 for the first entry; out_pred_pc values 0x2 then 0x102.
- PREDICT_BWD=1: BEQ with imm=-8 at 0x20 → next fetch 0x18. With PREDICT_BWD=0 → next fetch 0x24.
- JALR at 0x40 → FSM HALT, no mem_req for 10 cycles. redirect_valid with pc 0x80 → queue empty, next mem_req addr 0x80.
- redirect_valid while WAIT with mem_valid arriving 3 cycles later → response discarded, count stays 0, next request at redirect_pc.
- Queue full, deq_ready=1 for one cycle with simultaneous response → count stays DEPTH-1 then refills; head/tail wrap correctly over 3×DEPTH instructions; async rst_n mid-WAIT → all outputs at reset values immediately.

Source files
------------

// File: rtl/ifetch_queue_if.sv
// Fetch-unit bus bundle: memory request/response, redirect, stall and the
// decode-side output port. The fetch unit uses the slave view and its
// environment uses the master view.
interface ifetch_queue_if #(
    parameter int ADDR_W = 32,
    parameter int DEPTH  = 16
);
    localparam int CNT_W = $clog2(DEPTH) + 1;

    logic              stall;
    logic              mem_req;
    logic [ADDR_W-1:0] mem_addr;
    logic              mem_valid;
    logic [31:0]       mem_data;
    logic              redirect_valid;
    logic [ADDR_W-1:0] redirect_pc;
    logic              out_valid;
    logic              deq_ready;
    logic [31:0]       out_inst;
    logic [ADDR_W-1:0] out_pc;
    logic              out_is_c;
    logic [ADDR_W-1:0] out_pred_pc;
    logic [CNT_W-1:0]  count;

    modport slave (
        input  stall, mem_valid, mem_data, redirect_valid, redirect_pc, deq_ready,
        output mem_req, mem_addr, out_valid, out_inst, out_pc, out_is_c, out_pred_pc, count
    );

    modport master (
        output stall, mem_valid, mem_data, redirect_valid, redirect_pc, deq_ready,
        input  mem_req, mem_addr, out_valid, out_inst, out_pc, out_is_c, out_pred_pc, count
    );
endinterface

// File: rtl/ifetch_queue.sv
// RV32IC instruction fetch unit: one outstanding memory fetch, predecode of
// each returned word (length, direct jump targets, backward-taken branches),
// and a circular queue of fetched instructions feeding decode.
//
// state  | meaning
// -------+-------------------------------------------------------------
// S_IDLE | no request outstanding; issue at fetch_pc when allowed
// S_WAIT | request outstanding; drop=1 means its response is discarded
// S_HALT | indirect jump fetched; wait for the back end to redirect
module ifetch_queue #(
    parameter int                DEPTH       = 16,
    parameter int                ADDR_W      = 32,
    parameter logic [ADDR_W-1:0] RESET_PC    = '0,
    parameter bit                PREDICT_BWD = 1'b1
) (
    input  logic          clk,
    input  logic          rst_n,
    ifetch_queue_if.slave bus
);
    localparam int               PTR_W = $clog2(DEPTH);
    localparam int               CNT_W = PTR_W + 1;
    localparam logic [CNT_W-1:0] FULL  = CNT_W'(DEPTH);

    typedef enum logic [1:0] {S_IDLE, S_WAIT, S_HALT} state_t;

    state_t            state;
    logic [ADDR_W-1:0] fetch_pc;
    logic [ADDR_W-1:0] mem_addr_q;
    logic              mem_req_q;
    logic              drop;
    logic [PTR_W-1:0]  head;
    logic [PTR_W-1:0]  tail;
    logic [CNT_W-1:0]  count_q;

    logic [31:0]       q_inst [DEPTH];
    logic [ADDR_W-1:0] q_pc   [DEPTH];
    logic [ADDR_W-1:0] q_pred [DEPTH];
    logic              q_is_c [DEPTH];

    // Predecode of the returned word; mem_addr_q still holds its PC.
    logic [31:0]       d;
    logic [15:0]       c;
    logic [20:0]       j_imm;
    logic [12:0]       b_imm;
    logic [11:0]       cj_imm;
    logic [8:0]        cb_imm;
    logic              pd_is_c;
    logic              pd_indirect;
    logic [ADDR_W-1:0] pd_seq;
    logic [ADDR_W-1:0] pd_next;
    logic [31:0]       pd_inst;

    assign d      = bus.mem_data;
    assign c      = d[15:0];
    assign j_imm  = {d[31], d[19:12], d[20], d[30:21], 1'b0};
    assign b_imm  = {d[31], d[7], d[30:25], d[11:8], 1'b0};
    assign cj_imm = {c[12], c[8], c[10:9], c[6], c[7], c[2], c[11], c[5:3], 1'b0};
    assign cb_imm = {c[12], c[6:5], c[2], c[11:10], c[4:3], 1'b0};

    // Length, next-PC prediction and indirect detection for the response word.
    always_comb begin
        pd_is_c     = (d[1:0] != 2'b11);
        pd_seq      = mem_addr_q + (pd_is_c ? ADDR_W'(2) : ADDR_W'(4));
        pd_next     = pd_seq;
        pd_indirect = 1'b0;
        pd_inst     = pd_is_c ? {16'h0000, c} : d;
        if (!pd_is_c) begin
            case (d[6:0])
                7'h6F: pd_next = mem_addr_q + {{(ADDR_W-21){j_imm[20]}}, j_imm};
                7'h63: if (PREDICT_BWD && d[31])
                           pd_next = mem_addr_q + {{(ADDR_W-13){b_imm[12]}}, b_imm};
                7'h67: pd_indirect = 1'b1;
                default: ;
            endcase
        end else begin
            case ({c[15:13], c[1:0]})
                5'b101_01,
                5'b001_01: pd_next = mem_addr_q + {{(ADDR_W-12){cj_imm[11]}}, cj_imm};
                5'b110_01,
                5'b111_01: if (PREDICT_BWD && c[12])
                               pd_next = mem_addr_q + {{(ADDR_W-9){cb_imm[8]}}, cb_imm};
                5'b100_10: if (c[6:2] == 5'd0 && c[11:7] != 5'd0) pd_indirect = 1'b1;
                default: ;
            endcase
        end
    end

    logic             enq;
    logic             deq;
    logic [CNT_W-1:0] count_next;

    // Redirect suppresses both queue operations in its cycle.
    assign deq        = (count_q != '0) && bus.deq_ready && !bus.redirect_valid;
    assign enq        = (state == S_WAIT) && bus.mem_valid && !drop && !bus.redirect_valid;
    assign count_next = count_q + CNT_W'(enq) - CNT_W'(deq);

    // Fetch FSM; a non-indirect response chains straight into the next request.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= S_IDLE;
            fetch_pc   <= RESET_PC;
            mem_req_q  <= 1'b0;
            mem_addr_q <= RESET_PC;
            drop       <= 1'b0;
        end else begin
            mem_req_q <= 1'b0;
            if (bus.redirect_valid) begin
                fetch_pc <= bus.redirect_pc;
                // A response arriving with the redirect is simply discarded.
                if (state == S_WAIT && !bus.mem_valid) begin
                    drop  <= 1'b1;
                    state <= S_WAIT;
                end else begin
                    drop  <= 1'b0;
                    state <= S_IDLE;
                end
            end else begin
                case (state)
                    S_IDLE: begin
                        if (!bus.stall && count_q < FULL) begin
                            mem_req_q  <= 1'b1;
                            mem_addr_q <= fetch_pc;
                            state      <= S_WAIT;
                        end
                    end
                    S_WAIT: begin
                        if (bus.mem_valid) begin
                            if (drop) begin
                                drop  <= 1'b0;
                                state <= S_IDLE;
                            end else if (pd_indirect) begin
                                fetch_pc <= pd_next;
                                state    <= S_HALT;
                            end else begin
                                fetch_pc <= pd_next;
                                if (!bus.stall && count_next < FULL) begin
                                    mem_req_q  <= 1'b1;
                                    mem_addr_q <= pd_next;
                                    state      <= S_WAIT;
                                end else begin
                                    state <= S_IDLE;
                                end
                            end
                        end
                    end
                    S_HALT: ;
                    default: state <= S_IDLE;
                endcase
            end
        end
    end

    // Queue pointers and occupancy.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            head    <= '0;
            tail    <= '0;
            count_q <= '0;
        end else if (bus.redirect_valid) begin
            head    <= '0;
            tail    <= '0;
            count_q <= '0;
        end else begin
            if (enq) tail <= tail + PTR_W'(1);
            if (deq) head <= head + PTR_W'(1);
            count_q <= count_next;
        end
    end

    // Queue storage; contents are only meaningful below count.
    always_ff @(posedge clk) begin
        if (enq) begin
            q_inst[tail] <= pd_inst;
            q_pc[tail]   <= mem_addr_q;
            q_pred[tail] <= pd_next;
            q_is_c[tail] <= pd_is_c;
        end
    end

    a_no_overflow: assert property (@(posedge clk) disable iff (!rst_n) !(enq && count_q == FULL));

    assign bus.mem_req     = mem_req_q;
    assign bus.mem_addr    = mem_addr_q;
    assign bus.out_valid   = (count_q != '0);
    assign bus.out_inst    = q_inst[head];
    assign bus.out_pc      = q_pc[head];
    assign bus.out_is_c    = q_is_c[head];
    assign bus.out_pred_pc = q_pred[head];
    assign bus.count       = count_q;
endmodule

// File: tb/tb_ifetch_queue.sv
// Randomised bench for ifetch_queue: a memory responder with random latency,
// random stall/dequeue/redirect, a reference predecoder and a scoreboard of
// expected queue entries popped by an independent output monitor.
module tb_ifetch_queue;
    localparam int          DEPTH       = 8;
    localparam int          ADDR_W      = 32;
    localparam logic [31:0] RESET_PC    = 32'h0;
    localparam bit          PREDICT_BWD = 1'b1;

    logic clk   = 1'b0;
    logic rst_n = 1'b1;
    always #5 clk = ~clk;

    ifetch_queue_if #(.ADDR_W(ADDR_W), .DEPTH(DEPTH)) bus ();

    ifetch_queue #(
        .DEPTH(DEPTH), .ADDR_W(ADDR_W), .RESET_PC(RESET_PC), .PREDICT_BWD(PREDICT_BWD)
    ) dut (
        .clk(clk), .rst_n(rst_n), .bus(bus)
    );

    typedef struct {
        logic [31:0] inst;
        logic [31:0] pc;
        logic [31:0] pred;
        logic        is_c;
    } exp_t;

    exp_t        sb[$];
    int          checks   = 0;
    int          failures = 0;

    bit          outst, halted, exp_req;
    logic [31:0] exp_pc, req_pc;
    int          epoch = 0, req_epoch, resp_wait;
    bit          seq_only;
    int          p_deq, p_stall, p_redir;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference predecoder: offsets assembled arithmetically from the ISA fields.
    function automatic void ref_decode(input logic [31:0] pc, input logic [31:0] d,
                                       output logic [31:0] nxt, output bit ind, output bit cmp);
        int          off;
        logic [15:0] c;
        c   = d[15:0];
        cmp = (d[1:0] != 2'b11);
        ind = 1'b0;
        nxt = pc + (cmp ? 32'd2 : 32'd4);
        if (!cmp) begin
            if (d[6:0] == 7'h6F) begin
                off = 2*int'(d[30:21]) + 2048*int'(d[20]) + 4096*int'(d[19:12]) - (d[31] ? (1 << 20) : 0);
                nxt = pc + 32'(off);
            end else if (d[6:0] == 7'h63 && PREDICT_BWD && d[31]) begin
                off = 2*int'(d[11:8]) + 32*int'(d[30:25]) + 2048*int'(d[7]) - 4096;
                nxt = pc + 32'(off);
            end else if (d[6:0] == 7'h67) begin
                ind = 1'b1;
            end
        end else begin
            if (c[1:0] == 2'b01 && (c[15:13] == 3'b101 || c[15:13] == 3'b001)) begin
                off = 2*int'(c[5:3]) + 16*int'(c[11]) + 32*int'(c[2]) + 64*int'(c[7])
                    + 128*int'(c[6]) + 256*int'(c[10:9]) + 1024*int'(c[8]) - 2048*int'(c[12]);
                nxt = pc + 32'(off);
            end else if (c[1:0] == 2'b01 && c[15:14] == 2'b11 && PREDICT_BWD && c[12]) begin
                off = 2*int'(c[4:3]) + 8*int'(c[11:10]) + 32*int'(c[2]) + 64*int'(c[6:5]) - 256;
                nxt = pc + 32'(off);
            end else if (c[1:0] == 2'b10 && c[15:13] == 3'b100 && c[6:2] == 5'd0 && c[11:7] != 5'd0) begin
                ind = 1'b1;
            end
        end
    endfunction

    function automatic logic [31:0] gen_inst(input bit seq);
        logic [31:0] r;
        int          k;
        r = $urandom;
        k = seq ? $urandom_range(0, 1) : $urandom_range(0, 19);
        case (k)
            0, 10, 11: return {r[31:15], 3'b000, r[11:7], 7'h13};
            1, 12, 13: return {r[31:16], 3'b000, r[12:2], 2'b01};
            2:         return {r[31:7], 7'h6F};
            3, 14:     return {r[31:7], 7'h63};
            4:         return {r[31:7], 7'h67};
            5:         return {r[31:16], 3'b101, r[12:2], 2'b01};
            6:         return {r[31:16], 3'b001, r[12:2], 2'b01};
            7, 15:     return {r[31:16], 2'b11, r[13:2], 2'b01};
            8:         return {r[31:16], 3'b100, r[12:7], (r[0] ? r[6:2] : 5'd0), 2'b10};
            17:        return 32'h1000006F;
            18:        return {1'b1, 6'b111111, 5'd0, 5'd1, 3'b000, 4'b1100, 1'b1, 7'h63};
            default:   return r;
        endcase
    endfunction

    task automatic model_reset();
        sb.delete();
        outst   = 1'b0;
        halted  = 1'b0;
        exp_req = 1'b0;
        exp_pc  = RESET_PC;
        epoch++;
    endtask

    task automatic idle_inputs();
        bus.stall          = 1'b0;
        bus.deq_ready      = 1'b0;
        bus.redirect_valid = 1'b0;
        bus.redirect_pc    = '0;
        bus.mem_valid      = 1'b0;
        bus.mem_data       = '0;
    endtask

    // One cycle at the falling edge: check outputs, respond, drive inputs, advance model.
    task automatic step();
        bit          resp, redir, dq, st, req_now, ind, cmp, nreq;
        logic [31:0] data, nxt, rpc;
        int          size_after;
        exp_t        e;
        chk("count", 32'(bus.count), 32'(sb.size()));
        chk("out_valid", 32'(bus.out_valid), 32'(sb.size() != 0));
        chk("mem_req", 32'(bus.mem_req), 32'(exp_req));
        req_now = bus.mem_req;
        if (req_now) begin
            chk("mem_addr", bus.mem_addr, exp_pc);
            outst     = 1'b1;
            req_pc    = exp_pc;
            req_epoch = epoch;
            resp_wait = $urandom_range(1, 4);
        end else if (outst) begin
            resp_wait--;
        end
        resp  = outst && !req_now && resp_wait == 0;
        st    = ($urandom_range(0, 99) < p_stall);
        dq    = ($urandom_range(0, 99) < p_deq);
        redir = ($urandom_range(0, 99) < (halted ? 25 : p_redir));
        rpc   = $urandom & 32'hFFFF_FFFE;
        data  = gen_inst(seq_only);

        bus.stall          = st;
        bus.deq_ready      = dq;
        bus.redirect_valid = redir;
        bus.redirect_pc    = rpc;
        bus.mem_valid      = resp;
        bus.mem_data       = data;

        size_after = sb.size() - ((sb.size() != 0 && dq && !redir) ? 1 : 0);
        nreq = 1'b0;
        if (resp) begin
            outst = 1'b0;
            if (req_epoch == epoch && !redir) begin
                ref_decode(req_pc, data, nxt, ind, cmp);
                e.inst = cmp ? {16'h0000, data[15:0]} : data;
                e.pc   = req_pc;
                e.pred = nxt;
                e.is_c = cmp;
                sb.push_back(e);
                size_after++;
                exp_pc = nxt;
                if (ind) halted = 1'b1;
                nreq = !st && !ind && size_after < DEPTH;
            end
        end else if (!outst && !halted) begin
            nreq = !st && sb.size() < DEPTH;
        end
        if (redir) begin
            nreq   = 1'b0;
            epoch++;
            sb.delete();
            exp_pc = rpc;
            halted = 1'b0;
        end
        exp_req = nreq;
    endtask

    task automatic run(input int n);
        repeat (n) begin
            step();
            @(negedge clk);
        end
    endtask

    task automatic chk_reset_outputs(input string tag);
        chk({tag, " mem_req"}, 32'(bus.mem_req), 32'd0);
        chk({tag, " mem_addr"}, bus.mem_addr, RESET_PC);
        chk({tag, " out_valid"}, 32'(bus.out_valid), 32'd0);
        chk({tag, " count"}, 32'(bus.count), 32'd0);
    endtask

    // Output monitor: every accepted head must match the oldest expected entry.
    initial begin : monitor
        exp_t e;
        forever begin
            @(negedge clk);
            #2;
            if (rst_n && bus.out_valid && bus.deq_ready && !bus.redirect_valid) begin
                if (sb.size() == 0) begin
                    checks++;
                    failures++;
                    $display("FAIL head: dequeued pc %h but no entry expected at %0t", bus.out_pc, $time);
                end else begin
                    e = sb.pop_front();
                    chk("out_pc", bus.out_pc, e.pc);
                    chk("out_inst", bus.out_inst, e.inst);
                    chk("out_is_c", 32'(bus.out_is_c), 32'(e.is_c));
                    chk("out_pred_pc", bus.out_pred_pc, e.pred);
                end
            end
        end
    end

    initial begin : driver
        bit found;
        idle_inputs();
        model_reset();
        #1 rst_n = 1'b0;
        #11;
        chk_reset_outputs("reset");
        @(negedge clk);
        rst_n = 1'b1;

        // Sequential code, no consumer: queue fills and requests stop at DEPTH.
        seq_only = 1'b1; p_deq = 0; p_stall = 0; p_redir = 0;
        run(80);
        chk("fill count", 32'(bus.count), DEPTH);

        // Full random mix.
        seq_only = 1'b0; p_deq = 50; p_stall = 20; p_redir = 3;
        run(3000);

        // Fast consumer, no stalls: back-to-back fetch loop.
        p_deq = 90; p_stall = 0; p_redir = 2;
        run(1000);

        // Asynchronous reset while a fetch is outstanding.
        found = 1'b0;
        for (int i = 0; i < 200 && !found; i++) begin
            step();
            if (outst) found = 1'b1;
            else @(negedge clk);
        end
        if (!found) begin
            checks++;
            failures++;
            $display("FAIL async reset: no outstanding fetch within 200 cycles");
        end
        #3 rst_n = 1'b0;
        #1;
        chk_reset_outputs("async");
        idle_inputs();
        model_reset();
        @(negedge clk);
        rst_n = 1'b1;
        p_deq = 60; p_stall = 10; p_redir = 3;
        run(600);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
